// File: rtl/bt_link_pkg.sv
// rtl/bt_link_pkg.sv - shared state encoding and framing constants for bt_link_ctrl
package bt_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_COMPLETE = 3'd4
    } state_e;

    localparam logic [7:0]  CR     = 8'h0D;
    localparam logic [7:0]  LF     = 8'h0A;
    localparam logic [15:0] AT_END = 16'h0D0A;

endpackage

// File: rtl/bt_link_ctrl_sync_fifo.sv
// rtl/bt_link_ctrl_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bt_link_ctrl.sv
// rtl/bt_link_ctrl.sv - HC-05 link sequencer: word buffering, byte serialisation, AT response capture
module bt_link_ctrl
    import bt_link_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 5,
    parameter int TIMEOUT_CYC   = 500000
) (
    input  logic              CLK1MHZ,
    input  logic              resetn,
    input  logic              user_ready,
    input  logic              want_at,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              tx_full,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        rsp_data,
    input  logic              rsp_rd,
    output logic              rsp_empty,
    output logic [2:0]        state,
    output logic              done,
    output logic              timeout_err,
    output logic              rsp_overflow
);

    localparam int              NB     = DATA_W / 8;
    localparam int              KW     = $clog2(NB);
    localparam int              TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [KW-1:0]   K_LAST = KW'(NB - 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [KW-1:0]   k_q, k_d;
    logic            in_flight_q, in_flight_d;
    logic            busy_prev_q;
    logic            prev_cr_q, prev_cr_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            terr_q, terr_d;
    logic            ovf_q, ovf_d;

    logic            tx_push, tx_pop, tx_empty;
    logic [DATA_W-1:0] tx_head, tx_shift;
    logic            rx_push, rx_flush, rx_full;
    logic            busy_fall;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk     (CLK1MHZ),
        .resetn  (resetn),
        .flush_i (1'b0),
        .push_i  (tx_push),
        .wdata_i (wr_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk     (CLK1MHZ),
        .resetn  (resetn),
        .flush_i (rx_flush),
        .push_i  (rx_push),
        .wdata_i (rx_byte),
        .pop_i   (rsp_rd),
        .rdata_o (rsp_data),
        .full_o  (rx_full),
        .empty_o (rsp_empty)
    );

    // Byte k of the head word sits at the top after shifting by 8k.
    assign tx_shift  = tx_head << {k_q, 3'b000};
    assign busy_fall = busy_prev_q && !tx_busy;

    assign state        = state_q;
    assign timeout_err  = terr_q;
    assign rsp_overflow = ovf_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        k_d         = k_q;
        in_flight_d = in_flight_q;
        prev_cr_d   = prev_cr_q;
        tcnt_d      = tcnt_q;
        terr_d      = terr_q;
        ovf_d       = ovf_q;
        tx_push     = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        rx_flush    = 1'b0;
        tx_start    = 1'b0;
        tx_byte     = 8'h00;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (user_ready) begin
                    state_d     = ST_LOAD;
                    mode_d      = want_at;
                    terr_d      = 1'b0;
                    ovf_d       = 1'b0;
                    rx_flush    = want_at;
                    k_d         = '0;
                    in_flight_d = 1'b0;
                end
            end
            ST_LOAD: begin
                tx_push = wr_en && !tx_full;
                if (tx_full) begin
                    state_d = ST_SEND;
                end else if (mode_q && tx_push && (wr_data[15:0] == AT_END)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_byte = tx_shift[DATA_W-1 -: 8];
                // A byte stays in flight from its start pulse until the UART drops busy.
                if (in_flight_q) begin
                    if (busy_fall) begin
                        in_flight_d = 1'b0;
                        if (k_q == K_LAST) begin
                            k_d    = '0;
                            tx_pop = 1'b1;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end else if (!tx_empty) begin
                    if (!tx_busy) begin
                        tx_start    = 1'b1;
                        in_flight_d = 1'b1;
                    end
                end else if (!tx_busy) begin
                    state_d   = mode_q ? ST_WAIT_RSP : ST_COMPLETE;
                    tcnt_d    = '0;
                    prev_cr_d = 1'b0;
                end
            end
            ST_WAIT_RSP: begin
                tcnt_d = tcnt_q + 1'b1;
                if (rx_valid) begin
                    tcnt_d    = '0;
                    prev_cr_d = (rx_byte == CR);
                    if (rx_full) ovf_d = 1'b1;
                    else         rx_push = 1'b1;
                end
                if (tcnt_q == T_LAST) begin
                    state_d = ST_COMPLETE;
                    terr_d  = 1'b1;
                end else if (rx_valid && prev_cr_q && (rx_byte == LF)) begin
                    state_d = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                done = 1'b1;
                if (!user_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK1MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            k_q         <= '0;
            in_flight_q <= 1'b0;
            busy_prev_q <= 1'b0;
            prev_cr_q   <= 1'b0;
            tcnt_q      <= '0;
            terr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            in_flight_q <= in_flight_d;
            busy_prev_q <= tx_busy;
            prev_cr_q   <= prev_cr_d;
            tcnt_q      <= tcnt_d;
            terr_q      <= terr_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bt_link_ctrl.sv
// tb/tb_bt_link_ctrl.sv - scoreboard bench for bt_link_ctrl with UART model and reference queues
`timescale 1ns/1ps
module tb_bt_link_ctrl;

    localparam int DW  = 16;
    localparam int NB  = DW / 8;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int TO  = 100;

    logic          CLK1MHZ = 1'b0;
    logic          resetn = 1'b0;
    logic          user_ready = 1'b0;
    logic          want_at = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          tx_full;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    rsp_data;
    logic          rsp_rd = 1'b0;
    logic          rsp_empty;
    logic [2:0]    state;
    logic          done;
    logic          timeout_err;
    logic          rsp_overflow;

    int         checks = 0;
    int         errors = 0;
    int         busy_len = 3;
    int         bl = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic       exp_ovf = 1'b0;
    logic       prev_start = 1'b0;

    always #500 CLK1MHZ = ~CLK1MHZ;

    bt_link_ctrl #(
        .DATA_W(DW), .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK1MHZ(CLK1MHZ), .resetn(resetn), .user_ready(user_ready), .want_at(want_at),
        .wr_data(wr_data), .wr_en(wr_en), .tx_full(tx_full), .tx_byte(tx_byte),
        .tx_start(tx_start), .tx_busy(tx_busy), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_empty(rsp_empty), .state(state),
        .done(done), .timeout_err(timeout_err), .rsp_overflow(rsp_overflow)
    );

    // UART: busy for busy_len cycles starting the cycle after a start pulse.
    always @(posedge CLK1MHZ) begin
        if (!resetn)       bl <= 0;
        else if (tx_start) bl <= busy_len;
        else if (bl > 0)   bl <= bl - 1;
    end
    assign tx_busy = (bl > 0);

    always @(negedge CLK1MHZ) begin
        logic [7:0] e;
        if (resetn) begin
            if (tx_start) begin
                checks++;
                if (tx_busy || prev_start) begin
                    errors++;
                    $display("FAIL tx_start_spacing busy=%0b prev_start=%0b required 0/0", tx_busy, prev_start);
                end
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte_unexpected got %02h required no start", tx_byte);
                end else begin
                    e = exp_tx.pop_front();
                    if (tx_byte !== e) begin
                        errors++;
                        $display("FAIL tx_byte got %02h required %02h", tx_byte, e);
                    end
                end
            end
            if (rsp_rd && !rsp_empty) begin
                checks++;
                if (exp_rx.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_data_unexpected got %02h required empty", rsp_data);
                end else begin
                    e = exp_rx.pop_front();
                    if (rsp_data !== e) begin
                        errors++;
                        $display("FAIL rsp_data got %02h required %02h", rsp_data, e);
                    end
                end
            end
            prev_start = tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    initial begin
        #(60000 * 1000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLK1MHZ);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int n = 0;
        while (state !== s && n < max) begin
            cyc();
            n++;
        end
        chk(name, state, s);
    endtask

    task automatic start(input logic at);
        want_at = at;
        user_ready = 1'b1;
        cyc();
        chk("enter_load", state, 3'd1);
        if (at) begin
            exp_rx.delete();
            exp_ovf = 1'b0;
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w, input bit accepted);
        wr_en = 1'b1;
        wr_data = w;
        if (accepted)
            for (int k = 0; k < NB; k++) exp_tx.push_back(8'((w >> (8 * (NB - 1 - k))) & 'hFF));
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        cyc($urandom_range(0, 3));
        rx_byte = b;
        rx_valid = 1'b1;
        if (exp_rx.size() < RXD) exp_rx.push_back(b);
        else exp_ovf = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic pop_rsp(input int n);
        rsp_rd = 1'b1;
        cyc(n);
        rsp_rd = 1'b0;
    endtask

    task automatic finish_xfer();
        user_ready = 1'b0;
        cyc();
        chk("return_idle", state, 3'd0);
        chk("done_low_idle", done, 1'b0);
    endtask

    task automatic run_data(input logic [4*DW-1:0] ws);
        start(1'b0);
        for (int i = 0; i < TXD; i++) write_word(ws[4*DW-1-DW*i -: DW], 1'b1);
        chk("tx_full_after_fill", tx_full, 1'b1);
        chk("load_when_full", state, 3'd1);
        write_word(DW'($urandom), 1'b0);
        wait_state(3'd4, 3000, "data_complete");
        chk("done_in_complete", done, 1'b1);
        chk("tx_all_sent", exp_tx.size(), 0);
        finish_xfer();
    endtask

    initial begin
        logic [7:0] b;
        int n;

        cyc(2);
        chk("rst_state", state, 3'd0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_overflow", rsp_overflow, 1'b0);
        chk("rst_rsp_empty", rsp_empty, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        resetn = 1'b1;
        cyc();

        // Fixed data-mode transfer, plus COMPLETE holding while user_ready stays high.
        start(1'b0);
        write_word(16'h1234, 1'b1);
        write_word(16'h5678, 1'b1);
        write_word(16'h9ABC, 1'b1);
        write_word(16'hDEF0, 1'b1);
        wait_state(3'd4, 3000, "data_fixed_complete");
        cyc(3);
        chk("complete_holds", state, 3'd4);
        chk("data_fixed_sent", exp_tx.size(), 0);
        finish_xfer();

        // AT exchange with "OK" response.
        start(1'b1);
        write_word(16'h4154, 1'b1);
        chk("at_still_load", state, 3'd1);
        write_word(16'h0D0A, 1'b1);
        chk("at_send_after_term", state, 3'd2);
        wait_state(3'd3, 500, "at_wait_rsp");
        chk("at_all_sent", exp_tx.size(), 0);
        send_rx(8'h4F);
        send_rx(8'h4B);
        send_rx(8'h0D);
        chk("at_cr_alone_waits", state, 3'd3);
        send_rx(8'h0A);
        chk("at_complete_crlf", state, 3'd4);
        chk("at_timeout_err", timeout_err, 1'b0);
        chk("at_overflow", rsp_overflow, exp_ovf);
        pop_rsp(2);
        chk("at_rsp_nonempty", rsp_empty, (exp_rx.size() == 0));
        finish_xfer();

        // Data mode keeps RX contents; reset mid-SEND then aborts everything.
        start(1'b0);
        chk("data_keeps_rx", rsp_empty, (exp_rx.size() == 0));
        for (int i = 0; i < TXD; i++) write_word(DW'($urandom), 1'b1);
        n = 0;
        while (exp_tx.size() > TXD * NB - 3 && n < 2000) begin
            cyc();
            n++;
        end
        chk("rst_mid_send_state", state, 3'd2);
        resetn = 1'b0;
        #1;
        chk("rst_mid_state", state, 3'd0);
        chk("rst_mid_tx_start", tx_start, 1'b0);
        chk("rst_mid_tx_full", tx_full, 1'b0);
        chk("rst_mid_rsp_empty", rsp_empty, 1'b1);
        exp_tx.delete();
        exp_rx.delete();
        user_ready = 1'b0;
        cyc(3);
        resetn = 1'b1;
        cyc();
        run_data({DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});

        // AT timeout, then timeout_err cleared on the next start.
        start(1'b1);
        write_word(16'h0D0A, 1'b1);
        wait_state(3'd3, 500, "to_wait_rsp");
        n = 0;
        while (state !== 3'd4 && n < 1000) begin
            cyc();
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_err_set", timeout_err, 1'b1);
        finish_xfer();
        start(1'b1);
        chk("timeout_err_cleared", timeout_err, 1'b0);

        // RX overflow: six bytes then CR-LF into a four-byte FIFO.
        write_word(16'h0D0A, 1'b1);
        wait_state(3'd3, 500, "ovf_wait_rsp");
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(8'h20, 8'h7E));
            send_rx(b);
        end
        send_rx(8'h0D);
        send_rx(8'h0A);
        chk("ovf_complete", state, 3'd4);
        chk("ovf_flag", rsp_overflow, exp_ovf);
        chk("ovf_no_timeout", timeout_err, 1'b0);
        pop_rsp(RXD + 1);
        chk("ovf_rsp_empty", rsp_empty, 1'b1);
        chk("ovf_rsp_all_popped", exp_rx.size(), 0);
        finish_xfer();

        // Long UART busy periods.
        busy_len = 50;
        run_data({DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});

        repeat (3) begin
            busy_len = $urandom_range(1, 6);
            run_data({DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_link_ctrl.md
Name: bt_link_ctrl

Overview:
- Parametrised Bluetooth link sequencer between host/sensor word sources and an external byte UART (uart_tx/uart_rx) driving the HC-05 module.
- Buffers DATA_W-bit words in an internal TX FIFO and serialises each word MSB-byte-first to the UART.
- In AT mode, it captures the module's CR-LF terminated response into an RX byte FIFO, with an inactivity timeout.
- Replaces the fixed 16-bit, single-mode sequencer. Adds latched mode, byte serialisation, timeout and overflow reporting.

Parameters:
- DATA_W, 16, word width; multiple of 8, ≥16.
- TX_DEPTH_LOG2, 4, TX FIFO depth = 2^TX_DEPTH_LOG2 words.
- RX_DEPTH_LOG2, 5, RX FIFO depth = 2^RX_DEPTH_LOG2 bytes.
- TIMEOUT_CYC, 500000, AT-response inactivity limit in clock cycles (0.5 s at 1 MHz).

Ports:
- CLK1MHZ, in, 1, clock.
- resetn, in, 1, asynchronous active-low reset.
- user_ready, in, 1, level; start request / completion acknowledge.
- want_at, in, 1, mode select: 1 = AT command, 0 = data stream; sampled on IDLE→LOAD.
- wr_data, in, DATA_W, word to buffer.
- wr_en, in, 1, write strobe; honoured only in LOAD.
- tx_full, out, 1, TX FIFO full.
- tx_byte, out, 8, byte to UART.
- tx_start, out, 1, one-cycle UART start pulse.
- tx_busy, in, 1, UART busy.
- rx_byte, in, 8, received byte.
- rx_valid, in, 1, one-cycle received-byte strobe.
- rsp_data, out, 8, RX FIFO head; first-word-fall-through.
- rsp_rd, in, 1, RX FIFO pop.
- rsp_empty, out, 1, RX FIFO empty.
- state, out, 3, current FSM state.
- done, out, 1, high in COMPLETE.
- timeout_err, out, 1, sticky; last AT exchange timed out.
- rsp_overflow, out, 1, sticky; response byte dropped because the RX FIFO was full.

Behaviour:
- Reset (resetn low, asynchronous), all cleared:
  - state=IDLE; both FIFOs emptied.
  - tx_start, tx_byte, done, timeout_err, rsp_overflow all 0.
  - Timeout counter, byte index and mode_r cleared.
- Reset asserted mid-operation aborts immediately. No partial byte is re-sent after reset release.
- State encoding: IDLE=0, LOAD=1, SEND=2, WAIT_RSP=3, COMPLETE=4.
- IDLE: when user_ready=1, next=LOAD on that edge.
  - Latch mode_r=want_at.
  - Clear timeout_err and rsp_overflow.
  - If want_at=1, also flush the RX FIFO.
- LOAD: wr_en && !tx_full pushes wr_data; wr_en while full is ignored.
  - mode_r=1: go to SEND the cycle after a push whose low 16 bits are 16'h0D0A; also go to SEND if the FIFO becomes full.
  - mode_r=0: go to SEND when the FIFO becomes full.
  - wr_en outside LOAD is ignored.
- SEND: byte index k runs 0..DATA_W/8-1 over the head word.
  - tx_byte = word[DATA_W-1-8k -: 8].
  - tx_start pulses for 1 cycle only when tx_busy=0 and no start was issued in the previous cycle. The UART asserts tx_busy the cycle after tx_start.
  - Advance k when tx_busy falls. Pop the word after its last byte.
  - When the FIFO is empty and tx_busy=0: next=WAIT_RSP if mode_r=1, else COMPLETE.
- WAIT_RSP: each rx_valid byte is pushed to the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and rsp_overflow is set; the byte still counts for terminator detection.
  - A CR byte followed immediately (next received byte) by an LF byte → COMPLETE.
  - Timeout counter resets on entry and on each rx_valid. Reaching TIMEOUT_CYC-1 → COMPLETE with timeout_err=1.
  - rx_valid on the same cycle the timeout expires: the byte is accepted and the timeout still wins.
- rx_valid outside WAIT_RSP is ignored.
- COMPLETE: done=1; stay while user_ready=1; return to IDLE when user_ready=0.
- RX FIFO pop (rsp_rd && !rsp_empty) is legal in any state. A simultaneous push and pop are both honoured; a pop on empty is ignored.
- FIFO pointers are TX_DEPTH_LOG2+1 / RX_DEPTH_LOG2+1 bits; full/empty come from the MSB compare, so wrap-around is transparent.

Decomposition:
- Package bt_link_pkg holds:
  - state encodings;
  - CR=8'h0D, LF=8'h0A, AT_END=16'h0D0A.
- One sub-module, sync_fifo (parametrised WIDTH, DEPTH_LOG2, first-word-fall-through, asynchronous active-low reset, flush input).
  - Instantiated twice: TX (DATA_W wide) and RX (8 bits wide).

Test Plan:
- Data mode, DATA_W=16, depth 4: user_ready=1, want_at=0, write 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0.
  - Expected: tx_byte sequence 12,34,56,78,9A,BC,DE,F0; one tx_start per byte; then COMPLETE, done=1.
  - Dropping user_ready → IDLE.
- AT mode: write 16'h4154 ("AT") then 16'h0D0A.
  - Expected: SEND right after the second push; bytes 41,54,0D,0A.
  - Inject rx bytes 4F,4B,0D,0A ("OK") → COMPLETE; rsp_data pops 4F,4B,0D,0A, then rsp_empty=1.
- Timeout: AT exchange with no rx_valid, TIMEOUT_CYC=100.
  - Expected: COMPLETE exactly 100 cycles after WAIT_RSP entry; timeout_err=1.
  - timeout_err clears on the next start.
- RX overflow, RX_DEPTH_LOG2=2: send 6 bytes then 0D,0A.
  - Expected: 4 bytes stored, rsp_overflow=1, COMPLETE still reached on CR-LF.
- Backpressure: hold tx_busy high for 50 cycles after each start.
  - Expected: no second tx_start during busy; byte order preserved.
  - wr_en while tx_full → write ignored.
- Reset in SEND after 3 bytes.
  - Expected: state=IDLE, tx_start=0, FIFOs empty.
  - A new transfer after release starts from byte 0 of the new data.
